pattern_tx_gen: RTL



---
 rtl/pattern_tx_pkg.sv | 20 ++
 rtl/pattern_tx_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the benches that
// drive or observe it.
package pattern_tx_pkg;

    // Default widths: pattern length, repeat-count width, gap width.
    localparam int unsigned PAT_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned GAP_W_DEF = 3;

    // Canonical pattern looked for by the serial bit-pattern detectors.
    localparam logic [3:0] DET_PATTERN = 4'b1010;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/pattern_tx_gen.sv
// Serial pattern transmitter: on an accepted start, latches pattern, repeat
// count and gap, then sends the pattern MSB-first once per clock, repeat_cnt
// times, with gap idle cycles between copies. All outputs are registered.
module pattern_tx_gen
    import pattern_tx_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             sout,
    output logic             sout_vld,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    tx_state_e        state_q,   state_d;
    logic [PAT_W-1:0] pat_q,     pat_d;
    logic [PAT_W-1:0] sh_q,      sh_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] copies_q,  copies_d;
    logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             sout_q,    sout_d;
    logic             vld_q,     vld_d;
    logic             fs_q,      fs_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    // Next-state logic: the registered outputs always describe the bit that is
    // on the line after the edge, so each branch computes what to show next.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        sh_d      = sh_q;
        bit_idx_d = bit_idx_q;
        copies_d  = copies_q;
        gap_lat_d = gap_lat_q;
        gap_cnt_d = gap_cnt_q;
        sout_d    = 1'b0;
        vld_d     = 1'b0;
        fs_d      = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (repeat_cnt != '0) begin
                        state_d   = SEND;
                        pat_d     = pattern;
                        copies_d  = repeat_cnt;
                        gap_lat_d = gap;
                        bit_idx_d = LAST_IDX;
                        sout_d    = pattern[PAT_W-1];
                        sh_d      = pattern << 1;
                        vld_d     = 1'b1;
                        fs_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_idx_q != '0) begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                    sout_d    = sh_q[PAT_W-1];
                    sh_d      = sh_q << 1;
                    vld_d     = 1'b1;
                end else begin
                    // Bit 0 of a copy was on the line; copies_q still counts it.
                    copies_d = copies_q - CNT_W'(1);
                    if (copies_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (gap_lat_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_lat_q - GAP_W'(1);
                    end else begin
                        bit_idx_d = LAST_IDX;
                        sout_d    = pat_q[PAT_W-1];
                        sh_d      = pat_q << 1;
                        vld_d     = 1'b1;
                        fs_d      = 1'b1;
                    end
                end
            end

            GAP: begin
                // The first idle cycle is shown on entry, so the counter is
                // loaded with gap-1 and the next copy starts when it hits 0.
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d   = SEND;
                    bit_idx_d = LAST_IDX;
                    sout_d    = pat_q[PAT_W-1];
                    sh_d      = pat_q << 1;
                    vld_d     = 1'b1;
                    fs_d      = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            sh_q      <= '0;
            bit_idx_q <= '0;
            copies_q  <= '0;
            gap_lat_q <= '0;
            gap_cnt_q <= '0;
            sout_q    <= 1'b0;
            vld_q     <= 1'b0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            sh_q      <= sh_d;
            bit_idx_q <= bit_idx_d;
            copies_q  <= copies_d;
            gap_lat_q <= gap_lat_d;
            gap_cnt_q <= gap_cnt_d;
            sout_q    <= sout_d;
            vld_q     <= vld_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sout        = sout_q;
    assign sout_vld    = vld_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
